// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter between byte requesters
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int FRAME_CYCLES = 11,
    parameter int GAP_CYCLES   = 0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [NUM_REQ*8-1:0]       i_req_data,
    output logic [NUM_REQ-1:0]         o_req_ready,
    output logic                       o_tx_start,
    output logic [7:0]                 o_tx_data,
    output logic                       o_busy,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id
);

    localparam int IW   = $clog2(NUM_REQ);
    localparam int SPAN = FRAME_CYCLES + GAP_CYCLES;
    localparam int CW   = ($clog2(SPAN + 1) > 9) ? $clog2(SPAN + 1) : 9;
    localparam logic [CW-1:0] WAIT_LOAD = CW'(FRAME_CYCLES - 2 + GAP_CYCLES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] rr_ptr;
    logic [CW-1:0] wait_cnt;
    logic          win_found;
    logic [IW-1:0] win_idx;
    logic          accept;

    // Search starts just above the last winner so every requester gets a turn
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!win_found && i_req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = IW'(idx);
            end
        end
    end

    assign accept      = (state == ST_IDLE) && i_en && win_found && !i_rst;
    assign o_req_ready = accept ? (NUM_REQ'(1) << win_idx) : '0;
    assign o_busy      = (state != ST_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            o_tx_start <= 1'b0;
            o_tx_data  <= 8'h00;
            o_grant_id <= '0;
            rr_ptr     <= IW'(NUM_REQ - 1);
            wait_cnt   <= '0;
        end else begin
            o_tx_start <= accept;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        o_tx_data  <= i_req_data[{win_idx, 3'b000} +: 8];
                        rr_ptr     <= win_idx;
                        o_grant_id <= win_idx;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= (WAIT_LOAD != '0) ? ST_WAIT : ST_IDLE;
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - CW'(1);
                    if (wait_cnt == CW'(1)) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
